// File: rtl/fpkt_enq_arb.sv
// Two-source round-robin arbiter feeding a single-entry fetch-packet buffer.
// Holds a stalled offer (LOCK) until it is accepted, and blocks offers for a fixed window after a flush.
module fpkt_enq_arb #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             req0_valid,
    input  logic [254:0]     req0_pkt,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [254:0]     req1_pkt,
    output logic             req1_ready,
    output logic             q_enq_valid,
    input  logic             q_enq_ready,
    output logic [254:0]     q_enq_pkt,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
    output logic [7:0]       flush_cnt
);

    localparam int unsigned PKT_W = 255;
    localparam int unsigned BLK_W = 3;
    localparam int unsigned FCN_W = 8;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e             state_q;
    logic               locked_sel_q;
    logic               last_grant_q;
    logic [BLK_W-1:0]   blk_cnt_q;
    logic [CNT_W-1:0]   grant_cnt0_q;
    logic [CNT_W-1:0]   grant_cnt1_q;
    logic [FCN_W-1:0]   flush_cnt_q;

    logic               grant_c;
    logic               sel_valid_c;
    logic               enq_valid_c;
    logic               hs_c;

    // Source selection: LOCK pins the stalled source, ARB alternates on ties.
    always_comb begin
        grant_c = ~last_grant_q;
        case (state_q)
            ST_LOCK: grant_c = locked_sel_q;
            ST_ARB: begin
                if (req0_valid && !req1_valid) begin
                    grant_c = 1'b0;
                end else if (req1_valid && !req0_valid) begin
                    grant_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign sel_valid_c = grant_c ? req1_valid : req0_valid;
    assign enq_valid_c = sel_valid_c && (state_q != ST_FLUSH) && !flush && !reset;
    assign hs_c        = enq_valid_c && q_enq_ready;

    assign q_enq_valid = enq_valid_c;
    assign q_enq_pkt   = enq_valid_c ? (grant_c ? req1_pkt : req0_pkt) : PKT_W'(0);
    assign req0_ready  = hs_c && !grant_c;
    assign req1_ready  = hs_c && grant_c;

    assign grant_cnt0  = grant_cnt0_q;
    assign grant_cnt1  = grant_cnt1_q;
    assign flush_cnt   = flush_cnt_q;

    // Flush overrides any handshake or lock transition in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_ARB;
            locked_sel_q <= 1'b0;
            last_grant_q <= 1'b1;
            blk_cnt_q    <= BLK_W'(0);
            grant_cnt0_q <= CNT_W'(0);
            grant_cnt1_q <= CNT_W'(0);
            flush_cnt_q  <= FCN_W'(0);
        end else if (flush) begin
            state_q   <= ST_FLUSH;
            blk_cnt_q <= BLK_W'(FLUSH_CYCLES);
            if (flush_cnt_q != {FCN_W{1'b1}}) begin
                flush_cnt_q <= flush_cnt_q + FCN_W'(1);
            end
        end else if (hs_c) begin
            state_q      <= ST_ARB;
            last_grant_q <= grant_c;
            if (!grant_c && (grant_cnt0_q != {CNT_W{1'b1}})) begin
                grant_cnt0_q <= grant_cnt0_q + CNT_W'(1);
            end
            if (grant_c && (grant_cnt1_q != {CNT_W{1'b1}})) begin
                grant_cnt1_q <= grant_cnt1_q + CNT_W'(1);
            end
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (enq_valid_c) begin
                        state_q      <= ST_LOCK;
                        locked_sel_q <= grant_c;
                    end
                end
                ST_LOCK: begin
                    if (!sel_valid_c) begin
                        state_q <= ST_ARB;
                    end
                end
                ST_FLUSH: begin
                    blk_cnt_q <= blk_cnt_q - BLK_W'(1);
                    if (blk_cnt_q <= BLK_W'(1)) begin
                        state_q <= ST_ARB;
                    end
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_fpkt_enq_arb.sv
// Directed bench for fpkt_enq_arb: expected accepts go into a scoreboard queue that a
// negedge monitor drains on every buffer handshake; counters and blocking are checked inline.
module tb_fpkt_enq_arb;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned FLUSH_CYCLES = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             flush;
    logic             req0_valid, req1_valid;
    logic [254:0]     req0_pkt, req1_pkt;
    logic             req0_ready, req1_ready;
    logic             q_enq_valid, q_enq_ready;
    logic [254:0]     q_enq_pkt;
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
    logic [7:0]       flush_cnt;

    typedef struct packed {
        logic         src;
        logic [254:0] pkt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   pid    = 0;

    fpkt_enq_arb #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_pkt   (req0_pkt),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_pkt   (req1_pkt),
        .req1_ready (req1_ready),
        .q_enq_valid(q_enq_valid),
        .q_enq_ready(q_enq_ready),
        .q_enq_pkt  (q_enq_pkt),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .flush_cnt  (flush_cnt)
    );

    always #5 clock = ~clock;

    function automatic logic [254:0] mk_pkt(input logic src, input int id);
        return {7'h55, src, 8'(id), 239'(64'hC0DE_0000_0000_0000 + 64'(id) + (src ? 64'h1_0000 : 64'h0))};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sets inputs for one cycle with fresh packets on both sources.
    task automatic drive(input logic v0, input logic v1, input logic rdy, input logic fl, input logic rst);
        pid++;
        req0_valid  = v0;
        req1_valid  = v1;
        req0_pkt    = mk_pkt(1'b0, pid);
        req1_pkt    = mk_pkt(1'b1, pid);
        q_enq_ready = rdy;
        flush       = fl;
        reset       = rst;
    endtask

    task automatic expect_acc(input logic src);
        exp_t e;
        e.src = src;
        e.pkt = src ? req1_pkt : req0_pkt;
        sb.push_back(e);
    endtask

    task automatic to_neg();
        @(negedge clock);
    endtask

    task automatic to_next();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every handshake must match the head of the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (q_enq_valid && q_enq_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_accept: r0=%0b r1=%0b expected no accept at %0t", req0_ready, req1_ready, $time);
            end else begin
                e = sb.pop_front();
                if (req0_ready !== !e.src || req1_ready !== e.src || q_enq_pkt !== e.pkt) begin
                    errors++;
                    $display("FAIL accept: got r0=%0b r1=%0b pkt_lo=%0h expected src=%0b pkt_lo=%0h at %0t",
                             req0_ready, req1_ready, q_enq_pkt[63:0], e.src, e.pkt[63:0], $time);
                end
            end
        end else if (!q_enq_valid) begin
            checks++;
            if (q_enq_pkt !== 255'(0) || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs: pkt_lo=%0h r0=%0b r1=%0b expected 0 at %0t",
                         q_enq_pkt[63:0], req0_ready, req1_ready, $time);
            end
        end
    end

    initial begin
        // Reset with both sources requesting: nothing may be offered.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        to_neg();
        chk("reset_valid", 64'(q_enq_valid), 64'd0);
        to_next();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        to_neg();
        chk("reset_ready", 64'({req0_ready, req1_ready}), 64'd0);
        to_next();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        to_neg();
        chk("reset_cnt0", 64'(grant_cnt0), 64'd0);
        chk("reset_cnt1", 64'(grant_cnt1), 64'd0);
        chk("reset_fcnt", 64'(flush_cnt), 64'd0);
        to_next();

        // Round-robin on ties: 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            expect_acc(1'(i % 2));
            to_neg();
            to_next();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        to_neg();
        chk("rr_cnt0", 64'(grant_cnt0), 64'd2);
        chk("rr_cnt1", 64'(grant_cnt1), 64'd2);
        to_next();

        // Single accept from source 0 so a tie would now favour source 1.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_acc(1'b0);
        to_neg();
        to_next();

        // Stalled offer from source 0 stays locked while source 1 joins.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        to_neg();
        chk("stall_valid", 64'(q_enq_valid), 64'd1);
        to_next();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            to_neg();
            chk("lock_pkt", q_enq_pkt[63:0], req0_pkt[63:0]);
            to_next();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_acc(1'b0);
        to_neg();
        to_next();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_acc(1'b1);
        to_neg();
        to_next();

        // Locked source drops valid: back to ARB, other source granted next.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        to_neg();
        to_next();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        to_neg();
        chk("drop_valid", 64'(q_enq_valid), 64'd0);
        to_next();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_acc(1'b1);
        to_neg();
        to_next();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        to_neg();
        chk("pre_flush_cnt0", 64'(grant_cnt0), 64'd4);
        chk("pre_flush_cnt1", 64'(grant_cnt1), 64'd4);
        to_next();

        // One-cycle flush against a ready buffer: three blocked cycles, then the offer resumes.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        to_neg();
        chk("flush_valid", 64'(q_enq_valid), 64'd0);
        to_next();
        for (int i = 0; i < int'(FLUSH_CYCLES); i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            to_neg();
            chk("flush_block", 64'(q_enq_valid), 64'd0);
            chk("flush_cnt", 64'(flush_cnt), 64'd1);
            chk("flush_cnt0", 64'(grant_cnt0), 64'd4);
            to_next();
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_acc(1'b0);
        to_neg();
        chk("flush_resume", 64'(q_enq_valid), 64'd1);
        to_next();

        // Reset while source 1 is locked: outputs quiet, then source 0 wins the first tie.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        to_neg();
        to_next();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            to_neg();
            chk("lock_reset_valid", 64'(q_enq_valid), 64'd0);
            to_next();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_acc(1'b0);
        to_neg();
        chk("post_reset_fcnt", 64'(flush_cnt), 64'd0);
        chk("post_reset_cnt1", 64'(grant_cnt1), 64'd0);
        to_next();

        // 2^CNT_W+3 accepts from source 1: counter saturates at all-ones.
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            expect_acc(1'b1);
            to_neg();
            to_next();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        to_neg();
        chk("sat_cnt1", 64'(grant_cnt1), 64'd15);
        chk("sat_cnt0", 64'(grant_cnt0), 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        to_next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
